// File: rtl/serial_add_unit.sv
// Bit-serial adder: a full-adder slice made of two half adders and an OR gate,
// fed LSB-first from operand shift registers, with a carry flip-flop closing the loop.

module serial_add_ha (
   input  logic x,
   input  logic y,
   output logic s,
   output logic co
);
   assign s  = x ^ y;
   assign co = x & y;
endmodule

// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// ADD   | one bit per cycle, LSB first, WIDTH cycles
// DONE  | result presented; held until out_ready
module serial_add_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt, sum_q;
   logic [CW-1:0]    cnt;
   logic             c, cout_q;
   logic             s1, c1, s2, c2, c_nxt;
   logic             last;

   serial_add_ha u_ha1 (.x(a_sr[0]), .y(b_sr[0]), .s(s1), .co(c1));
   serial_add_ha u_ha2 (.x(s1),      .y(c),       .s(s2), .co(c2));

   assign c_nxt = c1 | c2;
   assign last  = (cnt == CW'(WIDTH - 1));

   // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 is the first one produced.
   generate
      if (WIDTH == 1) begin : g_sum_w1
         assign sum_nxt = s2;
      end else begin : g_sum_wn
         assign sum_nxt = {s2, sum_sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = ADD;
         ADD:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  sum_sr <= '0;
                  c      <= 1'b0;
                  cnt    <= '0;
               end
            end
            ADD: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_nxt;
               c      <= c_nxt;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  sum_q  <= sum_nxt;
                  cout_q <= c_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum       = sum_q;
   assign carry_out = cout_q;

endmodule
